// File: rtl/hw_scan_pkg.sv
// hw_scan_pkg: shared slot geometry, FSM state type and highest-slot helper for the scan sequencer
package hw_scan_pkg;
  localparam int NUM_SLOTS = 8;
  localparam int SEL_W = 3;
  typedef enum logic [1:0] {IDLE, DWELL, GAP} scan_state_t;
  function automatic logic [SEL_W-1:0] top_slot(input logic [NUM_SLOTS-1:0] m);
    top_slot = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (m[i]) top_slot = SEL_W'(i);
  endfunction
endpackage

// File: rtl/hw_scan_next_slot.sv
// hw_scan_next_slot: finds the lowest set mask bit and the next set bit strictly above cur
// Ports: mask (slot enables), cur (current slot) -> nxt (next slot above cur),
//        first (lowest enabled slot), last (no enabled slot above cur)
module hw_scan_next_slot
  import hw_scan_pkg::*;
(
  input  logic [NUM_SLOTS-1:0] mask,
  input  logic [SEL_W-1:0]     cur,
  output logic [SEL_W-1:0]     nxt,
  output logic [SEL_W-1:0]     first,
  output logic                 last
);
  // Scan downward so the final hit is the lowest qualifying bit.
  always_comb begin
    first = '0;
    nxt = '0;
    last = 1'b1;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (mask[i]) first = SEL_W'(i);
      if (mask[i] && i > int'(cur)) begin
        nxt = SEL_W'(i);
        last = 1'b0;
      end
    end
  end
endmodule

// File: rtl/hw_3_8_scan_sequencer.sv
// hw_3_8_scan_sequencer: masked, dwell-timed slot scanner driving the EN/s inputs of a 3:8 decoder
// Ports: clk, rst_n (async active-low), start, stop, cont, mask, dwell in;
//        EN, s, busy, slot_done, sweep_done out (all from registers).
// Build option: define SCAN_GAP_EN for a one-cycle EN=0 gap between slots.
module hw_3_8_scan_sequencer
  import hw_scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 cont,
  input  logic [NUM_SLOTS-1:0] mask,
  input  logic [DWELL_W-1:0]   dwell,
  output logic                 EN,
  output logic [SEL_W-1:0]     s,
  output logic                 busy,
  output logic                 slot_done,
  output logic                 sweep_done
);
  scan_state_t state, state_n;
  logic [SEL_W-1:0] s_n, top_q, top_n, nxt, first;
  logic [NUM_SLOTS-1:0] msk_q, msk_n, sel_mask;
  logic [DWELL_W-1:0] dw_q, dw_n, cnt, cnt_n;
  logic last, en_n, cont_q, cont_n, slot_done_n, sweep_done_n;

  // While idle the candidate mask is the live input, otherwise the latched one.
  assign sel_mask = (state == IDLE) ? mask : msk_q;
  assign busy = (state != IDLE);

  hw_scan_next_slot u_next (
    .mask  (sel_mask),
    .cur   (s),
    .nxt   (nxt),
    .first (first),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      EN <= 1'b0;
      s <= '0;
      cnt <= '0;
      msk_q <= '0;
      dw_q <= '0;
      cont_q <= 1'b0;
      top_q <= '0;
      slot_done <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      state <= state_n;
      EN <= en_n;
      s <= s_n;
      cnt <= cnt_n;
      msk_q <= msk_n;
      dw_q <= dw_n;
      cont_q <= cont_n;
      top_q <= top_n;
      slot_done <= slot_done_n;
      sweep_done <= sweep_done_n;
    end
  end

  // Done flags are derived from the next-cycle state so they line up with counter==0.
  always_comb begin
    state_n = state;
    s_n = s;
    en_n = EN;
    cnt_n = cnt;
    msk_n = msk_q;
    dw_n = dw_q;
    cont_n = cont_q;
    top_n = top_q;
    if (state == IDLE) begin
      if (start && !stop && |mask) begin
        state_n = DWELL;
        s_n = first;
        en_n = 1'b1;
        msk_n = mask;
        dw_n = (dwell == '0) ? DWELL_W'(1) : dwell;
        cnt_n = dw_n - 1'b1;
        cont_n = cont;
        top_n = top_slot(mask);
      end
    end else if (stop) begin
      state_n = IDLE;
      en_n = 1'b0;
    end else if (state == GAP) begin
      state_n = DWELL;
      en_n = 1'b1;
    end else if (cnt != '0) begin
      cnt_n = cnt - 1'b1;
    end else if (last && !cont_q) begin
      state_n = IDLE;
      en_n = 1'b0;
    end else begin
      s_n = last ? first : nxt;
      cnt_n = dw_q - 1'b1;
`ifdef SCAN_GAP_EN
      state_n = GAP;
      en_n = 1'b0;
`endif
    end
    slot_done_n = (state_n == DWELL) && (cnt_n == '0);
    sweep_done_n = slot_done_n && (s_n == top_n);
  end
endmodule
